// File: rtl/cpu_pkg.sv
// Shared widths, operand-select encoding and the ID/EX payload layout.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 2;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    SEL_RF    = 2'd0,
    SEL_EXMEM = 2'd1,
    SEL_MEMWB = 2'd2
  } opsel_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } idex_t;
endpackage

// File: rtl/operand_bypass_mux.sv
// Per-source bypass selection: EX/MEM (non-load) over MEM/WB over RF data.
module operand_bypass_mux
  import cpu_pkg::*;
(
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_ex_valid,
  input  logic              i_ex_write,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_valid,
  input  logic              i_mem_write,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_load_haz
);
  logic   w_ex_hit;
  logic   w_mem_hit;
  opsel_e w_sel;

  assign w_ex_hit   = i_use && i_ex_valid && i_ex_write && (i_ex_rd == i_src);
  assign w_mem_hit  = i_use && i_mem_valid && i_mem_write && (i_mem_rd == i_src);
  // A load in EX/MEM has no data yet; the stage stalls, so its select is irrelevant.
  assign o_load_haz = w_ex_hit && i_ex_is_load;

  always_comb begin
    w_sel = SEL_RF;
    if (w_ex_hit && !i_ex_is_load) w_sel = SEL_EXMEM;
    else if (w_mem_hit)            w_sel = SEL_MEMWB;
  end

  always_comb begin
    o_data = i_rf_data;
    case (w_sel)
      SEL_EXMEM: o_data = i_ex_data;
      SEL_MEMWB: o_data = i_mem_data;
      default:   o_data = i_rf_data;
    endcase
  end
endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: RF addressing, bypass, RAW stall and ID/EX register.
module operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_use_rs,
  input  logic              in_use_rt,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  output logic [REG_AW-1:0] rf_addr1,
  output logic [REG_AW-1:0] rf_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              ex_fwd_valid,
  input  logic              ex_fwd_write,
  input  logic              ex_fwd_is_load,
  input  logic [REG_AW-1:0] ex_fwd_rd,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              mem_fwd_valid,
  input  logic              mem_fwd_write,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [CNT_W-1:0]  stall_cnt
);
  idex_t             r_idex;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall;
  logic [DATA_W-1:0] w_rs_val, w_rt_val;
  logic              w_lh_rs, w_lh_rt;
  logic              w_idex_rs, w_idex_rt;
  logic              w_hazard, w_slot_free;

  assign rf_addr1 = in_rs;
  assign rf_addr2 = in_rt;

  operand_bypass_mux u_mux_rs (
    .i_use(in_use_rs), .i_src(in_rs), .i_rf_data(rf_data1),
    .i_ex_valid(ex_fwd_valid), .i_ex_write(ex_fwd_write), .i_ex_is_load(ex_fwd_is_load),
    .i_ex_rd(ex_fwd_rd), .i_ex_data(ex_fwd_data),
    .i_mem_valid(mem_fwd_valid), .i_mem_write(mem_fwd_write),
    .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .o_data(w_rs_val), .o_load_haz(w_lh_rs)
  );

  operand_bypass_mux u_mux_rt (
    .i_use(in_use_rt), .i_src(in_rt), .i_rf_data(rf_data2),
    .i_ex_valid(ex_fwd_valid), .i_ex_write(ex_fwd_write), .i_ex_is_load(ex_fwd_is_load),
    .i_ex_rd(ex_fwd_rd), .i_ex_data(ex_fwd_data),
    .i_mem_valid(mem_fwd_valid), .i_mem_write(mem_fwd_write),
    .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .o_data(w_rt_val), .o_load_haz(w_lh_rt)
  );

  // The held ID/EX producer has not executed yet, so it cannot be bypassed.
  assign w_idex_rs   = in_use_rs && r_valid && r_idex.reg_write && (r_idex.rd == in_rs);
  assign w_idex_rt   = in_use_rt && r_valid && r_idex.reg_write && (r_idex.rd == in_rt);
  assign w_hazard    = in_valid && (w_idex_rs || w_idex_rt || w_lh_rs || w_lh_rt);
  assign w_slot_free = !r_valid || out_ready;
  assign in_ready    = !flush && !w_hazard && w_slot_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_idex  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_valid           <= 1'b1;
      r_idex.op         <= in_op;
      r_idex.a          <= w_rs_val;
      r_idex.b          <= in_use_imm ? in_imm : w_rt_val;
      r_idex.store_data <= w_rt_val;
      r_idex.rd         <= in_rd;
      r_idex.reg_write  <= in_reg_write;
      r_idex.mem_read   <= in_mem_read;
      r_idex.mem_write  <= in_mem_write;
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_stall <= '0;
    else if (w_hazard && !flush && r_stall != '1) r_stall <= r_stall + 1'b1;
  end

  assign out_valid      = r_valid;
  assign out_op         = r_idex.op;
  assign out_a          = r_idex.a;
  assign out_b          = r_idex.b;
  assign out_store_data = r_idex.store_data;
  assign out_rd         = r_idex.rd;
  assign out_reg_write  = r_idex.reg_write;
  assign out_mem_read   = r_idex.mem_read;
  assign out_mem_write  = r_idex.mem_write;
  assign stall_cnt      = r_stall;
endmodule

// File: tb/tb_operand_stage.sv
// Directed bench: stimulus pushes expected ID/EX payloads, a monitor pops on each consume.
module tb_operand_stage;
  import cpu_pkg::*;

  logic clk, reset;
  logic in_valid, in_ready;
  logic [OP_W-1:0] in_op;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd;
  logic in_use_rs, in_use_rt, in_use_imm;
  logic [DATA_W-1:0] in_imm;
  logic in_reg_write, in_mem_read, in_mem_write;
  logic [REG_AW-1:0] rf_addr1, rf_addr2;
  logic [DATA_W-1:0] rf_data1, rf_data2;
  logic ex_fwd_valid, ex_fwd_write, ex_fwd_is_load;
  logic [REG_AW-1:0] ex_fwd_rd;
  logic [DATA_W-1:0] ex_fwd_data;
  logic mem_fwd_valid, mem_fwd_write;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [DATA_W-1:0] mem_fwd_data;
  logic flush, out_valid, out_ready;
  logic [OP_W-1:0] out_op;
  logic [DATA_W-1:0] out_a, out_b, out_store_data;
  logic [REG_AW-1:0] out_rd;
  logic out_reg_write, out_mem_read, out_mem_write;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  idex_t exp_q[$];

  operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_write(ex_fwd_write), .ex_fwd_is_load(ex_fwd_is_load),
    .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_write(mem_fwd_write),
    .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic idex_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] sd, input logic [1:0] rd,
                               input logic rw, input logic mr, input logic mw);
    idex_t e;
    e = '{op: op, a: a, b: b, store_data: sd, rd: rd, reg_write: rw, mem_read: mr, mem_write: mw};
    return e;
  endfunction

  // Monitor: every consumed ID/EX entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      idex_t got, e;
      got = '{op: out_op, a: out_a, b: out_b, store_data: out_store_data, rd: out_rd,
              reg_write: out_reg_write, mem_read: out_mem_read, mem_write: out_mem_write};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got op=%0h a=%0h b=%0h with nothing expected",
                 got.op, got.a, got.b);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL payload: got op=%0h a=%0h b=%0h sd=%0h rd=%0d ctl=%b%b%b expected op=%0h a=%0h b=%0h sd=%0h rd=%0d ctl=%b%b%b",
                   got.op, got.a, got.b, got.store_data, got.rd, got.reg_write, got.mem_read, got.mem_write,
                   e.op, e.a, e.b, e.store_data, e.rd, e.reg_write, e.mem_read, e.mem_write);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drv(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt,
                     input logic [1:0] rd, input logic urs, input logic urt, input logic uimm,
                     input logic [15:0] imm, input logic rw, input logic mr, input logic mw);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_use_rs = urs; in_use_rt = urt; in_use_imm = uimm; in_imm = imm;
    in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
  endtask

  task automatic set_ex(input logic v, input logic w, input logic ld, input logic [1:0] rd,
                        input logic [15:0] d);
    ex_fwd_valid = v; ex_fwd_write = w; ex_fwd_is_load = ld; ex_fwd_rd = rd; ex_fwd_data = d;
  endtask

  task automatic set_mem(input logic v, input logic w, input logic [1:0] rd, input logic [15:0] d);
    mem_fwd_valid = v; mem_fwd_write = w; mem_fwd_rd = rd; mem_fwd_data = d;
  endtask

  initial begin
    idex_t dropped;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    rf_data1 = '0; rf_data2 = '0;
    set_ex(0, 0, 0, 0, 0); set_mem(0, 0, 0, 0);

    // Reset state, then async reset with an entry held
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rf_addr_passthru", {rf_addr1, rf_addr2}, {2'd0, 2'd0});
    out_ready = 1'b0; rf_data1 = 16'h0007;
    drv(1, 0, 0, 0, 1, 0, 1, 16'h0001, 0, 0, 0);
    nxt();
    in_valid = 1'b0;
    #1 chk("held_before_reset", out_valid, 1);
    #1 reset = 1'b1;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_a", out_a, 0);
    chk("async_rst_stall", stall_cnt, 0);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    nxt();

    // RF path with immediate
    rf_data1 = 16'h1234; rf_data2 = 16'h5555;
    drv(1, 1, 0, 2, 1, 0, 1, 16'hFFF0, 1, 0, 0);
    chk("rf_addr1", rf_addr1, 1);
    exp_q.push_back(mk(1, 16'h1234, 16'hFFF0, 16'h5555, 2, 1, 0, 0));
    settle(); chk("rf_in_ready", in_ready, 1);
    nxt(); in_valid = 1'b0;
    settle(); chk("rf_out_valid", out_valid, 1);
    nxt();

    // Bypass priority: EX/MEM over MEM/WB over RF
    set_ex(1, 1, 0, 2, 16'h00AA); set_mem(1, 1, 2, 16'h00BB);
    rf_data1 = 16'h0001; rf_data2 = 16'h0000;
    drv(2, 2, 0, 0, 1, 0, 1, 16'h0000, 0, 0, 0);
    exp_q.push_back(mk(2, 16'h00AA, 16'h0000, 16'h0000, 0, 0, 0, 0));
    nxt();
    ex_fwd_valid = 1'b0;
    drv(3, 2, 0, 0, 1, 0, 1, 16'h0000, 0, 0, 0);
    exp_q.push_back(mk(3, 16'h00BB, 16'h0000, 16'h0000, 0, 0, 0, 0));
    nxt();
    // rs=rt on the same producer
    ex_fwd_valid = 1'b1;
    drv(4, 2, 2, 0, 1, 1, 0, 16'h0000, 0, 0, 0);
    exp_q.push_back(mk(4, 16'h00AA, 16'h00AA, 16'h00AA, 0, 0, 0, 0));
    nxt();
    // Register 0 bypassed like any other
    set_ex(0, 0, 0, 0, 0); set_mem(1, 1, 0, 16'h0C0C);
    drv(5, 0, 0, 0, 1, 1, 1, 16'h0003, 0, 0, 0);
    exp_q.push_back(mk(5, 16'h0C0C, 16'h0003, 16'h0C0C, 0, 0, 0, 0));
    nxt();
    in_valid = 1'b0; set_mem(0, 0, 0, 0);
    settle(); chk("no_stall_yet", stall_cnt, 0);
    nxt();

    // ALU-use: one bubble, then EX/MEM bypass
    rf_data1 = 16'h0003; rf_data2 = 16'h0004;
    drv(2, 0, 1, 3, 1, 1, 0, 16'h0000, 1, 0, 0);
    exp_q.push_back(mk(2, 16'h0003, 16'h0004, 16'h0004, 3, 1, 0, 0));
    nxt();
    rf_data1 = 16'h0000; rf_data2 = 16'h9999;
    drv(3, 0, 3, 1, 0, 1, 0, 16'h0000, 1, 0, 0);
    settle(); chk("alu_use_in_ready", in_ready, 0);
    nxt();
    set_ex(1, 1, 0, 3, 16'h0007);
    settle();
    chk("alu_use_bubble", out_valid, 0);
    chk("alu_use_stall", stall_cnt, 1);
    chk("alu_use_ready2", in_ready, 1);
    exp_q.push_back(mk(3, 16'h0000, 16'h0007, 16'h0007, 1, 1, 0, 0));
    nxt();

    // Load-use: two bubbles, then MEM/WB bypass
    set_ex(0, 0, 0, 0, 0);
    rf_data1 = 16'h0100; rf_data2 = 16'h0000;
    drv(8, 0, 0, 1, 1, 0, 1, 16'h0004, 1, 1, 0);
    exp_q.push_back(mk(8, 16'h0100, 16'h0004, 16'h0000, 1, 1, 1, 0));
    nxt();
    rf_data1 = 16'hAAAA;
    drv(5, 1, 0, 2, 1, 0, 1, 16'h0000, 1, 0, 0);
    settle(); chk("ld_use_ready_1", in_ready, 0);
    nxt();
    set_ex(1, 1, 1, 1, 16'hDEAD);
    settle();
    chk("ld_use_ready_2", in_ready, 0);
    chk("ld_use_stall_1", stall_cnt, 2);
    nxt();
    set_ex(0, 0, 0, 0, 0); set_mem(1, 1, 1, 16'h0BEE);
    settle();
    chk("ld_use_ready_3", in_ready, 1);
    chk("ld_use_stall_2", stall_cnt, 3);
    exp_q.push_back(mk(5, 16'h0BEE, 16'h0000, 16'h0000, 2, 1, 0, 0));
    nxt();

    // Backpressure then flush
    set_mem(0, 0, 0, 0);
    rf_data1 = 16'h1111; rf_data2 = 16'h0000;
    drv(6, 0, 0, 0, 0, 0, 1, 16'h2222, 0, 0, 0);
    exp_q.push_back(mk(6, 16'h1111, 16'h2222, 16'h0000, 0, 0, 0, 0));
    nxt();
    out_ready = 1'b0; rf_data1 = 16'h4444;
    drv(7, 0, 0, 0, 0, 0, 1, 16'h7777, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_payload", {out_op, out_a, out_b}, {4'd6, 16'h1111, 16'h2222});
      chk("bp_stall", stall_cnt, 3);
      nxt();
    end
    flush = 1'b1;
    settle(); chk("flush_in_ready", in_ready, 0);
    dropped = exp_q.pop_front();
    nxt();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    settle();
    chk("flush_valid", out_valid, 0);
    chk("flush_stall", stall_cnt, 3);
    repeat (3) nxt();
    chk("flushed_op", dropped.op, 6);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
